tlb_refill_ctrl: RTL
====================

Name: tlb_refill_ctrl

Overview:
Miss handler placed in front of the 8-entry fully associative TLB tag CAM. It watches each lookup's match result and, on a miss, stalls the pipeline. It then fetches the page-table entry (PTE) from memory over a request/acknowledge handshake and writes the VPN tag into the CAM at a round-robin victim slot, with the PFN sent to the companion data RAM. Invalid PTEs raise a one-cycle page-fault pulse instead of a refill.

Parameters:
PTE_VALID_BIT, 0, bit index of the valid flag in the fetched PTE
CNT_W, 16, width of the saturating refill counter

Ports:
clk  in  1  clock, all state changes on rising edge
clrn  in  1  reset, asynchronous, active-low
lookup_req  in  1  a translation lookup is presented this cycle
vpn  in  20  virtual page number of the lookup
mfound  in  1  CAM match flag for the current vpn
ptbr  in  32  page-table base address
stall  out  1  pipeline hold, miss in service
pte_req  out  1  memory read request, held until acknowledged
pte_addr  out  32  PTE address, ptbr + {vpn_q,2'b00}, modulo 2^32
pte_ack  in  1  memory acknowledge, pte_data valid same cycle
pte_data  in  32  fetched PTE, PFN in [31:12]
tlb_wren  out  1  CAM/data-RAM write strobe
tlb_wraddress  out  3  victim entry index
tlb_pattern  out  20  tag to write (latched vpn)
tlb_pfn  out  20  PFN to write into the data RAM
page_fault  out  1  one-cycle pulse, invalid PTE
fault_vpn  out  20  vpn of the last fault, held until the next fault
refill_cnt  out  CNT_W  number of completed refills, saturating

Behaviour:
- Reset (clrn=0, asynchronous): state=IDLE; rr_ptr=0; vpn_q=0; the following outputs are 0: stall, pte_req, tlb_wren, page_fault, fault_vpn, refill_cnt. tlb_wraddress, tlb_pattern and tlb_pfn read 0.
- States: IDLE, REQ, WRITE, REPLAY, FAULT.
- IDLE:
  - stall = lookup_req & ~mfound, combinational. A miss stalls in the same cycle it is detected.
  - If lookup_req & ~mfound: latch vpn_q<=vpn and go to REQ. Otherwise stay in IDLE.
  - A hit (mfound=1) causes no action.
- REQ:
  - stall=1, pte_req=1, pte_addr = ptbr + {vpn_q,2'b00}. The address is registered from the ptbr value at miss entry and held stable.
  - Stay in REQ while pte_ack=0.
  - When pte_ack=1 at a clock edge:
    - PTE valid bit = 1: capture pfn_q<=pte_data[31:12] and go to WRITE.
    - PTE valid bit = 0: go to FAULT.
  - pte_req drops in the cycle after the ack.
- WRITE:
  - stall=1, tlb_wren=1 for exactly one cycle, tlb_wraddress=rr_ptr, tlb_pattern=vpn_q, tlb_pfn=pfn_q.
  - At the edge: rr_ptr<=rr_ptr+1 (7 wraps to 0); refill_cnt increments and saturates at all-ones.
  - Next state REPLAY.
- REPLAY:
  - stall=1 for one cycle while the CAM presents the new entry.
  - Next state IDLE. The replayed lookup then hits and stall deasserts.
- FAULT:
  - page_fault=1 for one cycle, fault_vpn<=vpn_q, stall=0, no CAM write, rr_ptr unchanged.
  - Next state IDLE.
- Outside WRITE, tlb_wren=0. tlb_wraddress, tlb_pattern and tlb_pfn are don't-care but must be driven from registers and must not toggle while tlb_wren=0.
- vpn and ptbr changes while the state is not IDLE are ignored; the latched values are used.
- pte_ack outside REQ is ignored.
- lookup_req is a don't-care outside IDLE.
- Refill latency from a miss in IDLE to the replay hit is 3 cycles plus the memory wait cycles in REQ.
- Replacement is pure round-robin regardless of entry validity. Duplicate tags cannot occur because refill happens only on a miss.
- Reset in any state aborts the operation immediately: pte_req and tlb_wren fall asynchronously and the partial refill is discarded.

Test Plan:
- Reset, then lookup_req=1 with mfound=1 -> stall=0, pte_req never asserts, refill_cnt=0.
- Miss with vpn=0x12345, ptbr=0x00100000 -> stall=1 in the same cycle; pte_addr=0x00148D14; pte_ack after 2 wait cycles with pte_data=0xABCDE001 -> tlb_wren single pulse, tlb_wraddress=0, tlb_pattern=0x12345, tlb_pfn=0xABCDE; stall falls one cycle after REPLAY; refill_cnt=1.
- Nine consecutive misses with distinct vpns, all valid PTEs -> tlb_wraddress sequence 0,1,…,7,0; refill_cnt=9.
- Miss with pte_data=0x00000000 -> page_fault pulses exactly 1 cycle, fault_vpn=vpn, no tlb_wren, rr_ptr unchanged (next refill still uses the previous pointer).
- clrn asserted while in REQ with pte_req=1 -> pte_req=0 immediately, stall=0, rr_ptr=0; a late pte_ack after reset is ignored.
- ptbr=0xFFFFFFF0, vpn=0x00004 -> pte_addr=0x00000000 (wraps modulo 2^32); refill_cnt preloaded near 0xFFFF stays saturated at 0xFFFF after a further refill.

Source files
------------

// File: rtl/tlb_refill_ctrl.sv
// TLB miss handler: stalls on a CAM miss, fetches the PTE and writes the tag/PFN
// into a round-robin victim slot, or pulses page_fault for an invalid PTE.
module tlb_refill_ctrl #(
    parameter int PTE_VALID_BIT = 0,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             lookup_req,
    input  logic [19:0]      vpn,
    input  logic             mfound,
    input  logic [31:0]      ptbr,
    output logic             stall,
    output logic             pte_req,
    output logic [31:0]      pte_addr,
    input  logic             pte_ack,
    input  logic [31:0]      pte_data,
    output logic             tlb_wren,
    output logic [2:0]       tlb_wraddress,
    output logic [19:0]      tlb_pattern,
    output logic [19:0]      tlb_pfn,
    output logic             page_fault,
    output logic [19:0]      fault_vpn,
    output logic [CNT_W-1:0] refill_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_WRITE  = 3'd2,
        S_REPLAY = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    state_t            r_state;
    logic [2:0]        r_rr_ptr;
    logic [19:0]       r_vpn_q;
    logic              r_pte_req;
    logic [31:0]       r_pte_addr;
    logic              r_tlb_wren;
    logic [2:0]        r_tlb_wraddress;
    logic [19:0]       r_tlb_pattern;
    logic [19:0]       r_tlb_pfn;
    logic              r_page_fault;
    logic [19:0]       r_fault_vpn;
    logic [CNT_W-1:0]  r_refill_cnt;

    logic              w_miss;
    logic              w_pte_valid;
    logic              w_unused;

    assign w_miss      = lookup_req & ~mfound;
    assign w_pte_valid = pte_data[PTE_VALID_BIT];
    assign w_unused    = ^pte_data[11:0];

    // Stall must rise in the very cycle the miss is seen, so it is decoded, not registered.
    always_comb begin
        stall = 1'b0;
        case (r_state)
            S_IDLE:                   stall = w_miss;
            S_REQ, S_WRITE, S_REPLAY: stall = 1'b1;
            default:                  stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state         <= S_IDLE;
            r_rr_ptr        <= 3'd0;
            r_vpn_q         <= 20'd0;
            r_pte_req       <= 1'b0;
            r_pte_addr      <= 32'd0;
            r_tlb_wren      <= 1'b0;
            r_tlb_wraddress <= 3'd0;
            r_tlb_pattern   <= 20'd0;
            r_tlb_pfn       <= 20'd0;
            r_page_fault    <= 1'b0;
            r_fault_vpn     <= 20'd0;
            r_refill_cnt    <= '0;
        end else begin
            r_tlb_wren   <= 1'b0;
            r_page_fault <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_miss) begin
                        r_vpn_q    <= vpn;
                        r_pte_addr <= ptbr + {10'd0, vpn, 2'b00};
                        r_pte_req  <= 1'b1;
                        r_state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (pte_ack) begin
                        r_pte_req <= 1'b0;
                        if (w_pte_valid) begin
                            // Write-port registers load only here so they stay quiet while wren is low.
                            r_tlb_wren      <= 1'b1;
                            r_tlb_wraddress <= r_rr_ptr;
                            r_tlb_pattern   <= r_vpn_q;
                            r_tlb_pfn       <= pte_data[31:12];
                            r_state         <= S_WRITE;
                        end else begin
                            r_page_fault <= 1'b1;
                            r_fault_vpn  <= r_vpn_q;
                            r_state      <= S_FAULT;
                        end
                    end
                end
                S_WRITE: begin
                    r_rr_ptr <= r_rr_ptr + 3'd1;
                    if (r_refill_cnt != '1)
                        r_refill_cnt <= r_refill_cnt + 1'b1;
                    r_state <= S_REPLAY;
                end
                S_REPLAY: r_state <= S_IDLE;
                S_FAULT:  r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    assign pte_req       = r_pte_req;
    assign pte_addr      = r_pte_addr;
    assign tlb_wren      = r_tlb_wren;
    assign tlb_wraddress = r_tlb_wraddress;
    assign tlb_pattern   = r_tlb_pattern;
    assign tlb_pfn       = r_tlb_pfn;
    assign page_fault    = r_page_fault;
    assign fault_vpn     = r_fault_vpn;
    assign refill_cnt    = r_refill_cnt;

endmodule
